// File: rtl/backend_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// backend_seq_ctrl_if
//
// Purpose : Framed serial configuration port of the analog backend sequencer.
//           The master (host / testbench) drives the port; the controller
//           receives it through the slave modport.
//
// Signals :
//   i_sclk  serial bit clock, asynchronous to the system clock
//   i_sdin  serial data, valid around the i_sclk rising edge
//   i_sen   frame enable, active high; one high window is one frame
// -----------------------------------------------------------------------------
interface backend_seq_ctrl_if;
    logic i_sclk;
    logic i_sdin;
    logic i_sen;

    modport master (output i_sclk, output i_sdin, output i_sen);
    modport slave  (input  i_sclk, input  i_sdin, input  i_sen);
endinterface : backend_seq_ctrl_if

// File: rtl/backend_seq_ctrl.sv
// -----------------------------------------------------------------------------
// backend_seq_ctrl
//
// Purpose : Receives an N_CH-channel gain frame over an oversampled serial
//           port, validates its length (and optionally its parity), then runs
//           the power-up sequence: VCO reset release, amplifier reset release,
//           ready. A new accepted frame at any time reloads the gains and
//           restarts the sequence.
//
// Optional feature:
//   BACKEND_PARITY_EN  defined   -> frame carries one trailing even-parity bit
//                      undefined -> no parity bit, only length is checked
//
// Ports :
//   i_clk        system clock
//   i_resetbAll  asynchronous active-low reset
//   ser          serial port (slave modport: i_sclk, i_sdin, i_sen)
//   o_gain       gains, channel k at [k*GAIN_W +: GAIN_W]
//   o_resetb     per-channel amplifier reset, active low
//   o_resetbvco  VCO reset, active low
//   o_ready      sequence complete
//   o_busy       sequencer active, from accept until o_ready rises
//   o_error      last frame rejected (sticky until the next accept)
// -----------------------------------------------------------------------------
module backend_seq_ctrl #(
    parameter int N_CH    = 2,
    parameter int GAIN_W  = 3,
    parameter int VCO_DLY = 2,
    parameter int AMP_DLY = 10,
    parameter int RDY_DLY = 10
) (
    input  logic                     i_clk,
    input  logic                     i_resetbAll,
    backend_seq_ctrl_if.slave        ser,
    output logic [N_CH*GAIN_W-1:0]   o_gain,
    output logic [N_CH-1:0]          o_resetb,
    output logic                     o_resetbvco,
    output logic                     o_ready,
    output logic                     o_busy,
    output logic                     o_error
);

    localparam int DATA_W = N_CH * GAIN_W;
`ifdef BACKEND_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_BITS = DATA_W + PAR_W;
    // Bit counter must hold FRAME_BITS+1 so over-long frames stay detectable.
    localparam int BCNT_W     = $clog2(FRAME_BITS + 2);
    localparam int MAX_VA     = (VCO_DLY > AMP_DLY) ? VCO_DLY : AMP_DLY;
    localparam int MAX_DLY    = (MAX_VA > RDY_DLY) ? MAX_VA : RDY_DLY;
    localparam int CNT_W      = $clog2(MAX_DLY + 1);

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_VCO,
        SEQ_AMP,
        SEQ_RDY,
        SEQ_DONE
    } seq_state_t;

    // -------------------------------------------------------------------------
    // Synchronisers and edge detectors
    // -------------------------------------------------------------------------
    logic [1:0] sclk_sync;
    logic [1:0] sdin_sync;
    logic [1:0] sen_sync;
    logic       sclk_prev;
    logic       sen_prev;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours; blocking here would
    // collapse the two-flop synchroniser into a single stage.
    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            sclk_sync <= '0;
            sdin_sync <= '0;
            sen_sync  <= '0;
            sclk_prev <= 1'b0;
            sen_prev  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], ser.i_sclk};
            sdin_sync <= {sdin_sync[0], ser.i_sdin};
            sen_sync  <= {sen_sync[0],  ser.i_sen};
            sclk_prev <= sclk_sync[1];
            sen_prev  <= sen_sync[1];
        end
    end

    logic sclk_rise;
    logic sen_rise;
    logic sen_fall;

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign sen_rise  = sen_sync[1]  & ~sen_prev;
    assign sen_fall  = ~sen_sync[1] & sen_prev;

    // -------------------------------------------------------------------------
    // Frame receiver
    // -------------------------------------------------------------------------
    logic [FRAME_BITS-1:0] shreg;
    logic [BCNT_W-1:0]     bit_cnt;

    // Right shift: the first bit received (channel 0 LSB) ends up at bit 0.
    // Shift and insert are written without slicing so FRAME_BITS=1 is legal.
    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (sen_rise) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (sclk_rise && sen_sync[1]) begin
            if (bit_cnt < BCNT_W'(FRAME_BITS)) begin
                shreg <= (shreg >> 1) |
                         (FRAME_BITS'(sdin_sync[1]) << (FRAME_BITS - 1));
            end
            if (bit_cnt <= BCNT_W'(FRAME_BITS)) begin
                bit_cnt <= bit_cnt + BCNT_W'(1);
            end
        end
    end

    logic len_ok;
    logic par_ok;
    logic accept;
    logic reject;

    assign len_ok = (bit_cnt == BCNT_W'(FRAME_BITS));
`ifdef BACKEND_PARITY_EN
    // Even parity over data and parity bit together: XOR of all must be 0.
    assign par_ok = ~^shreg;
`else
    assign par_ok = 1'b1;
`endif
    assign accept = sen_fall &  (len_ok & par_ok);
    assign reject = sen_fall & ~(len_ok & par_ok);

    // -------------------------------------------------------------------------
    // Power-up sequencer
    // -------------------------------------------------------------------------
    seq_state_t          state,      state_nxt;
    logic [CNT_W-1:0]    cnt,        cnt_nxt;
    logic [DATA_W-1:0]   gain_nxt;
    logic [N_CH-1:0]     resetb_nxt;
    logic                resetbvco_nxt;
    logic                ready_nxt;
    logic                busy_nxt;
    logic                error_nxt;

    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            state       <= SEQ_IDLE;
            cnt         <= '0;
            o_gain      <= '0;
            o_resetb    <= '0;
            o_resetbvco <= 1'b0;
            o_ready     <= 1'b0;
            o_busy      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            o_gain      <= gain_nxt;
            o_resetb    <= resetb_nxt;
            o_resetbvco <= resetbvco_nxt;
            o_ready     <= ready_nxt;
            o_busy      <= busy_nxt;
            o_error     <= error_nxt;
        end
    end

    // NOTE: every signal written below gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        gain_nxt      = o_gain;
        resetb_nxt    = o_resetb;
        resetbvco_nxt = o_resetbvco;
        ready_nxt     = o_ready;
        busy_nxt      = o_busy;
        error_nxt     = o_error;

        if (accept) begin
            // Accept wins over whatever the sequencer was doing.
            gain_nxt      = shreg[DATA_W-1:0];
            resetb_nxt    = '0;
            resetbvco_nxt = 1'b0;
            ready_nxt     = 1'b0;
            busy_nxt      = 1'b1;
            error_nxt     = 1'b0;
            cnt_nxt       = CNT_W'(VCO_DLY);
            state_nxt     = SEQ_VCO;
        end else begin
            if (reject) begin
                error_nxt = 1'b1;
            end
            case (state)
                SEQ_VCO: begin
                    if (cnt == CNT_W'(1)) begin
                        resetbvco_nxt = 1'b1;
                        cnt_nxt       = CNT_W'(AMP_DLY);
                        state_nxt     = SEQ_AMP;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                SEQ_AMP: begin
                    if (cnt == CNT_W'(1)) begin
                        resetb_nxt = '1;
                        cnt_nxt    = CNT_W'(RDY_DLY);
                        state_nxt  = SEQ_RDY;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                SEQ_RDY: begin
                    if (cnt == CNT_W'(1)) begin
                        ready_nxt = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = SEQ_DONE;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: ;  // SEQ_IDLE and SEQ_DONE wait for an accept
            endcase
        end
    end

endmodule : backend_seq_ctrl

// File: tb/tb_backend_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_backend_seq_ctrl
//
// Two instances: dut_a with default parameters (2 x 3-bit gains, 2/10/10
// delays) and dut_b with N_CH=4, GAIN_W=2, delays 1/3/5. A behavioural model
// tracks, per instance, the last accepted gains, the sticky error and the
// time of the last accept; expected sequencer outputs are derived from the
// elapsed cycles since that accept. A monitor compares both instances against
// the model every cycle; a vector table, hand sequences and random frames
// drive the stimulus. BACKEND_PARITY_EN selects the parity build.
// -----------------------------------------------------------------------------
module tb_backend_seq_ctrl;

    localparam int PERIOD = 10;
`ifdef BACKEND_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int A_DW = 6, A_V = 2, A_A = 10, A_R = 10;
    localparam int B_DW = 8, B_V = 1, B_A = 3,  B_R = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #(PERIOD/2) clk = ~clk;

    backend_seq_ctrl_if ser_a ();
    backend_seq_ctrl_if ser_b ();

    logic [5:0] a_gain;
    logic [1:0] a_resetb;
    logic       a_vco, a_ready, a_busy, a_error;
    logic [7:0] b_gain;
    logic [3:0] b_resetb;
    logic       b_vco, b_ready, b_busy, b_error;

    backend_seq_ctrl dut_a (
        .i_clk       (clk),
        .i_resetbAll (rst_n),
        .ser         (ser_a),
        .o_gain      (a_gain),
        .o_resetb    (a_resetb),
        .o_resetbvco (a_vco),
        .o_ready     (a_ready),
        .o_busy      (a_busy),
        .o_error     (a_error)
    );

    backend_seq_ctrl #(
        .N_CH    (4),
        .GAIN_W  (2),
        .VCO_DLY (1),
        .AMP_DLY (3),
        .RDY_DLY (5)
    ) dut_b (
        .i_clk       (clk),
        .i_resetbAll (rst_n),
        .ser         (ser_b),
        .o_gain      (b_gain),
        .o_resetb    (b_resetb),
        .o_resetbvco (b_vco),
        .o_ready     (b_ready),
        .o_busy      (b_busy),
        .o_error     (b_error)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [7:0] m_gain    [2];
    bit         m_err     [2];
    bit         m_started [2];
    time        m_acc     [2];
    logic       fq[$];          // bits of the frame being sent, in wire order

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_gain[s] = '0; m_err[s] = 1'b0; m_started[s] = 1'b0; m_acc[s] = 0;
        end
    endtask

    // Frame closes at the current edge: judge it from the bits that were sent.
    task automatic model_close(input int s);
        int  dw, ones;
        bit  ok;
        logic [7:0] g;
        dw   = (s == 0) ? A_DW : B_DW;
        ok   = (fq.size() == dw + int'(PAR_EN));
        ones = 0;
        foreach (fq[i]) ones += int'(fq[i]);
        if (PAR_EN && (ones % 2 != 0)) ok = 1'b0;
        if (ok) begin
            g = '0;
            for (int i = 0; i < dw; i++) g[i] = fq[i];
            m_gain[s] = g; m_err[s] = 1'b0; m_started[s] = 1'b1; m_acc[s] = $time;
        end else begin
            m_err[s] = 1'b1;
        end
    endtask

    // Called at (edge + 1): outputs follow from cycles elapsed since accept.
    logic [7:0] e_gain;
    logic [3:0] e_rb;
    logic       e_vco, e_rdy, e_busy;

    task automatic model_expect(input int s);
        int t, v_at, rb_at, rd_at;
        v_at  = (s == 0) ? A_V : B_V;
        rb_at = v_at  + ((s == 0) ? A_A : B_A);
        rd_at = rb_at + ((s == 0) ? A_R : B_R);
        e_gain = m_gain[s];
        e_vco = 1'b0; e_rb = '0; e_rdy = 1'b0; e_busy = 1'b0;
        if (m_started[s]) begin
            t      = int'(($time - 1 - m_acc[s]) / PERIOD);
            e_vco  = (t >= v_at);
            e_rb   = (t >= rb_at) ? ((s == 0) ? 4'b0011 : 4'b1111) : 4'b0000;
            e_rdy  = (t >= rd_at);
            e_busy = (t <  rd_at);
        end
    endtask

    always @(posedge clk) begin
        #1;
        model_expect(0);
        check("A gain",   {26'd0, a_gain}, {24'd0, e_gain});
        check("A resetb", {30'd0, a_resetb}, {28'd0, e_rb});
        check("A vco",    {31'd0, a_vco},  {31'd0, e_vco});
        check("A ready",  {31'd0, a_ready}, {31'd0, e_rdy});
        check("A busy",   {31'd0, a_busy}, {31'd0, e_busy});
        check("A error",  {31'd0, a_error}, {31'd0, m_err[0]});
        model_expect(1);
        check("B gain",   {24'd0, b_gain}, {24'd0, e_gain});
        check("B resetb", {28'd0, b_resetb}, {28'd0, e_rb});
        check("B vco",    {31'd0, b_vco},  {31'd0, e_vco});
        check("B ready",  {31'd0, b_ready}, {31'd0, e_rdy});
        check("B busy",   {31'd0, b_busy}, {31'd0, e_busy});
        check("B error",  {31'd0, b_error}, {31'd0, m_err[1]});
    end

    // -------------------------------------------------------------------------
    // Serial drivers
    // -------------------------------------------------------------------------
    task automatic drive(input int s, input logic sclk, input logic sdin, input logic sen);
        if (s == 0) begin
            ser_a.i_sclk = sclk; ser_a.i_sdin = sdin; ser_a.i_sen = sen;
        end else begin
            ser_b.i_sclk = sclk; ser_b.i_sdin = sdin; ser_b.i_sen = sen;
        end
    endtask

    // Sends nbits data bits LSB first (plus an even-parity bit in the parity
    // build, inverted when bad_par) and returns at the frame-close edge.
    task automatic send_frame(input int s, input logic [31:0] data, input int nbits, input bit bad_par);
        logic p;
        fq.delete();
        p = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            fq.push_back(data[i]);
            p ^= data[i];
        end
        if (PAR_EN) fq.push_back(p ^ bad_par);
        @(negedge clk); drive(s, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        foreach (fq[i]) begin
            drive(s, 1'b0, fq[i], 1'b1); repeat (4) @(negedge clk);
            drive(s, 1'b1, fq[i], 1'b1); repeat (4) @(negedge clk);
        end
        drive(s, 1'b0, 1'b0, 1'b1); repeat (4) @(negedge clk);
        drive(s, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        model_close(s);
    endtask

    task automatic stray_pulses(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); drive(s, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            repeat (4) @(negedge clk); drive(s, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            repeat (3) @(negedge clk);
        end
    endtask

    // -------------------------------------------------------------------------
    // Vector table
    // -------------------------------------------------------------------------
    typedef struct {
        int          nbits;
        logic [31:0] data;
        bit          bad_par;
        logic [7:0]  exp_gain;   // right after the close edge
        bit          exp_err;
        bit          exp_busy;
        bit          exp_rdy;    // after the sequence has had time to finish
    } vec_t;

    vec_t tbl [5];

    initial begin
        #(PERIOD * 100000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef BACKEND_PARITY_EN
        tbl[0] = '{6, 32'b011101,   1'b1, 8'b000000, 1'b1, 1'b0, 1'b0};
`else
        tbl[0] = '{6, 32'b011101,   1'b1, 8'b011101, 1'b0, 1'b1, 1'b1};
`endif
        tbl[1] = '{6, 32'b011101,   1'b0, 8'b011101, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{5, 32'b10101,    1'b0, 8'b011101, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8, 32'hA5,       1'b0, 8'b011101, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{6, 32'b001111,   1'b0, 8'b001111, 1'b0, 1'b1, 1'b1};

        model_reset();
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset A gain",  {26'd0, a_gain}, 32'd0);
        check("reset A vco",   {31'd0, a_vco},  32'd0);
        check("reset B busy",  {31'd0, b_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven frames on dut_a
        for (int i = 0; i < 5; i++) begin
            send_frame(0, tbl[i].data, tbl[i].nbits, tbl[i].bad_par);
            @(negedge clk);
            check($sformatf("tbl%0d gain", i),  {26'd0, a_gain},  {24'd0, tbl[i].exp_gain});
            check($sformatf("tbl%0d error", i), {31'd0, a_error}, {31'd0, tbl[i].exp_err});
            check($sformatf("tbl%0d busy", i),  {31'd0, a_busy},  {31'd0, tbl[i].exp_busy});
            if (tbl[i].exp_busy) begin
                check($sformatf("tbl%0d ready@A", i), {31'd0, a_ready}, 32'd0);
                check($sformatf("tbl%0d vco@A", i),   {31'd0, a_vco},   32'd0);
            end
            repeat (25) @(negedge clk);
            check($sformatf("tbl%0d ready", i), {31'd0, a_ready}, {31'd0, tbl[i].exp_rdy});
        end

        // dut_b: stray clocks with i_sen low, then an 8-bit frame with 1/3/5 delays
        stray_pulses(1, 4);
        check("B stray gain", {24'd0, b_gain}, 32'd0);
        send_frame(1, 32'b10_01_11_00, 8, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);   // k edges after the accept edge
            if (k == 0) check("B gain@A", {24'd0, b_gain}, 32'b10_01_11_00);
            if (k == 0 || k == 1) check($sformatf("B vco A+%0d", k), {31'd0, b_vco}, (k >= 1) ? 32'd1 : 32'd0);
            if (k == 3 || k == 4) check($sformatf("B resetb A+%0d", k), {28'd0, b_resetb}, (k >= 4) ? 32'hF : 32'd0);
            if (k == 8 || k == 9) check($sformatf("B ready A+%0d", k), {31'd0, b_ready}, (k >= 9) ? 32'd1 : 32'd0);
            if (k == 5) stray_pulses(1, 0);
        end
        stray_pulses(1, 3);
        check("B stray gain2", {24'd0, b_gain}, 32'b10_01_11_00);

        // Asynchronous reset while dut_a is in SEQ_AMP
        send_frame(0, 32'b110010, 6, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst A gain",   {26'd0, a_gain},   32'd0);
        check("rst A resetb", {30'd0, a_resetb}, 32'd0);
        check("rst A vco",    {31'd0, a_vco},    32'd0);
        check("rst A busy",   {31'd0, a_busy},   32'd0);
        check("rst A ready",  {31'd0, a_ready},  32'd0);
        check("rst B gain",   {24'd0, b_gain},   32'd0);
        check("rst B ready",  {31'd0, b_ready},  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Random frames on both instances; the monitor checks every cycle
        for (int it = 0; it < 30; it++) begin
            int s, dw, r, nb;
            s  = int'($urandom_range(0, 1));
            dw = (s == 0) ? A_DW : B_DW;
            r  = int'($urandom_range(0, 5));
            nb = (r == 0) ? dw - 1 : (r == 1) ? dw + 1 : dw;
            if ($urandom_range(0, 3) == 0) stray_pulses(s, int'($urandom_range(1, 3)));
            send_frame(s, $urandom, nb, ($urandom_range(0, 4) == 0));
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_backend_seq_ctrl
